// File: rtl/draw_px_mux.sv
// draw_px_mux: selects one drawing engine's pixel stream (X, Y, colour) and
// forwards it to the framebuffer writer through a 2-entry main/skid buffer.
// Source changes wait until every buffered beat of the old source has left.
module draw_px_mux #(
  parameter int NUM_SRC  = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int C_W      = 8,
  parameter int SEL_W    = 4,
  parameter int IDLE_SEL = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [SEL_W-1:0]       SEL,
  input  logic                   SEL_LOAD,
  input  logic [NUM_SRC*X_W-1:0] IN_X,
  input  logic [NUM_SRC*Y_W-1:0] IN_Y,
  input  logic [NUM_SRC*C_W-1:0] IN_C,
  input  logic [NUM_SRC-1:0]     IN_VALID,
  output logic [NUM_SRC-1:0]     IN_READY,
  output logic [X_W-1:0]         OUT_X,
  output logic [Y_W-1:0]         OUT_Y,
  output logic [C_W-1:0]         OUT_C,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [SEL_W-1:0]       ACT_SEL,
  output logic                   BUSY,
  output logic                   SEL_ERR,
  output logic [15:0]            BEAT_CNT
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(IDLE_SEL);

  state_t           r_state;
  logic [SEL_W-1:0] r_act_sel;
  logic [SEL_W-1:0] r_pend;
  logic [1:0]       r_cnt;
  logic [X_W-1:0]   r_main_x, r_skid_x;
  logic [Y_W-1:0]   r_main_y, r_skid_y;
  logic [C_W-1:0]   r_main_c, r_skid_c;
  logic             r_sel_err;
  logic [15:0]      r_beat_cnt;

  logic             w_src_vld;
  logic [X_W-1:0]   w_src_x;
  logic [Y_W-1:0]   w_src_y;
  logic [C_W-1:0]   w_src_c;
  logic             w_push;
  logic             w_pop;
  logic [SEL_W-1:0] w_pend_eff;
  logic [NUM_SRC-1:0] w_in_ready;

  function automatic logic sel_legal(input logic [SEL_W-1:0] s);
    return int'(s) < NUM_SRC;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Route the active source's beat and build the one-hot ready vector
  always_comb begin
    w_src_vld  = 1'b0;
    w_src_x    = '0;
    w_src_y    = '0;
    w_src_c    = '0;
    w_in_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == r_act_sel) begin
        w_src_vld     = IN_VALID[i];
        w_src_x       = IN_X[i*X_W +: X_W];
        w_src_y       = IN_Y[i*Y_W +: Y_W];
        w_src_c       = IN_C[i*C_W +: C_W];
        w_in_ready[i] = (r_state == ST_RUN) && (r_cnt != 2'd2);
      end
    end
  end

  assign w_push     = (r_state == ST_RUN) && (r_cnt != 2'd2) && w_src_vld;
  assign w_pop      = (r_cnt != 2'd0) && OUT_READY;
  assign w_pend_eff = SEL_LOAD ? SEL : r_pend;

  // Main entry and occupancy: main always holds the oldest beat
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt    <= 2'd0;
      r_main_x <= '0;
      r_main_y <= '0;
      r_main_c <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_main_x <= w_src_x;
            r_main_y <= w_src_y;
            r_main_c <= w_src_c;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_main_x <= r_skid_x;
            r_main_y <= r_skid_y;
            r_main_c <= r_skid_c;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // push needs count<2 and pop needs count>0, so count is 1 here
          r_main_x <= w_src_x;
          r_main_y <= w_src_y;
          r_main_c <= w_src_c;
        end
        default: ;
      endcase
    end
  end

  // Skid entry captures the second beat when main is occupied and not leaving
  always_ff @(posedge CLK) begin
    if (w_push && !w_pop && (r_cnt == 2'd1)) begin
      r_skid_x <= w_src_x;
      r_skid_y <= w_src_y;
      r_skid_c <= w_src_c;
    end
  end

  // Select FSM: IDLE -> RUN on a legal load, RUN -> DRAIN on any load,
  // DRAIN applies the latest pending select once the buffer is empty
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_act_sel  <= IDLE_CODE;
      r_pend     <= IDLE_CODE;
      r_sel_err  <= 1'b0;
      r_beat_cnt <= 16'd0;
    end else begin
      r_sel_err <= 1'b0;
      if (w_pop) r_beat_cnt <= sat_inc(r_beat_cnt);
      case (r_state)
        ST_IDLE: begin
          if (SEL_LOAD) begin
            if (sel_legal(SEL)) begin
              r_act_sel  <= SEL;
              r_beat_cnt <= 16'd0;
              r_state    <= ST_RUN;
            end else if (SEL != IDLE_CODE) begin
              r_sel_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (SEL_LOAD) begin
            r_pend  <= SEL;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_pend <= w_pend_eff;
          if (r_cnt == 2'd0) begin
            if (sel_legal(w_pend_eff)) begin
              r_act_sel  <= w_pend_eff;
              r_beat_cnt <= 16'd0;
              r_state    <= ST_RUN;
            end else begin
              r_act_sel <= IDLE_CODE;
              r_state   <= ST_IDLE;
              if (w_pend_eff != IDLE_CODE) r_sel_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_X     = r_main_x;
  assign OUT_Y     = r_main_y;
  assign OUT_C     = r_main_c;
  assign OUT_VALID = (r_cnt != 2'd0);
  assign ACT_SEL   = r_act_sel;
  assign BUSY      = (r_state != ST_IDLE) || (r_cnt != 2'd0);
  assign SEL_ERR   = r_sel_err;
  assign BEAT_CNT  = r_beat_cnt;

endmodule

// File: tb/tb_draw_px_mux.sv
// Testbench for draw_px_mux: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_draw_px_mux;

  localparam int NS = 8;

  logic          CLK;
  logic          RST;
  logic [3:0]    SEL;
  logic          SEL_LOAD;
  logic [NS*10-1:0] IN_X;
  logic [NS*9-1:0]  IN_Y;
  logic [NS*8-1:0]  IN_C;
  logic [NS-1:0] IN_VALID;
  logic [NS-1:0] IN_READY;
  logic [9:0]    OUT_X;
  logic [8:0]    OUT_Y;
  logic [7:0]    OUT_C;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [3:0]    ACT_SEL;
  logic          BUSY;
  logic          SEL_ERR;
  logic [15:0]   BEAT_CNT;

  draw_px_mux dut (
    .CLK(CLK), .RST(RST), .SEL(SEL), .SEL_LOAD(SEL_LOAD),
    .IN_X(IN_X), .IN_Y(IN_Y), .IN_C(IN_C),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_X(OUT_X), .OUT_Y(OUT_Y), .OUT_C(OUT_C),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ACT_SEL(ACT_SEL), .BUSY(BUSY), .SEL_ERR(SEL_ERR), .BEAT_CNT(BEAT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [9:0] sx [NS];
  logic [8:0] sy [NS];
  logic [7:0] sc [NS];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      IN_X[i*10 +: 10] = sx[i];
      IN_Y[i*9 +: 9]   = sy[i];
      IN_C[i*8 +: 8]   = sc[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=drain, queue of buffered beats
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] c;
  } beat_t;

  beat_t m_q[$];
  int    m_mode, m_act, m_pend, m_bc;
  bit    m_err;

  task automatic model_reset();
    m_q.delete();
    m_mode = 0;
    m_act  = 15;
    m_pend = 15;
    m_bc   = 0;
    m_err  = 0;
  endtask

  task automatic check_all();
    logic [7:0] erdy;
    erdy = (m_mode == 1 && m_q.size() < 2) ? (8'b1 << m_act) : 8'b0;
    chk("in_ready", 32'(IN_READY), 32'(erdy));
    chk("out_valid", 32'(OUT_VALID), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_x", 32'(OUT_X), 32'(m_q[0].x));
      chk("out_y", 32'(OUT_Y), 32'(m_q[0].y));
      chk("out_c", 32'(OUT_C), 32'(m_q[0].c));
    end
    chk("act_sel", 32'(ACT_SEL), 32'(m_act));
    chk("busy", 32'(BUSY), 32'(m_mode != 0 || m_q.size() != 0));
    chk("sel_err", 32'(SEL_ERR), 32'(m_err));
    chk("beat_cnt", 32'(BEAT_CNT), 32'(m_bc));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic [3:0] sel, input logic ld, input logic [7:0] vld,
                      input logic ordy, output bit acc);
    int  n0, p;
    bit  push, pop;
    SEL       = sel;
    SEL_LOAD  = ld;
    IN_VALID  = vld;
    OUT_READY = ordy;
    n0   = m_q.size();
    push = (m_mode == 1) && (n0 < 2) && vld[m_act];
    pop  = (n0 > 0) && ordy;
    acc  = push;
    if (pop) begin
      void'(m_q.pop_front());
      if (m_bc < 65535) m_bc++;
    end
    if (push) m_q.push_back('{x: sx[m_act], y: sy[m_act], c: sc[m_act]});
    m_err = 0;
    case (m_mode)
      0: if (ld) begin
        if (sel < 8) begin m_act = int'(sel); m_bc = 0; m_mode = 1; end
        else if (sel != 15) m_err = 1;
      end
      1: if (ld) begin m_pend = int'(sel); m_mode = 2; end
      default: begin
        p = ld ? int'(sel) : m_pend;
        m_pend = p;
        if (n0 == 0) begin
          if (p < 8) begin m_act = p; m_bc = 0; m_mode = 1; end
          else begin m_act = 15; m_mode = 0; m_err = (p != 15); end
        end
      end
    endcase
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0] sel;
    logic       ld;
    logic [7:0] vld;
    logic       ordy;
    logic [7:0] e_rdy;
    logic       e_ov;
    logic [9:0] e_x;
    logic [3:0] e_act;
    logic [15:0] e_bc;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tv [10];

  initial begin
    bit acc;
    bit saw3;
    int sent;

    tv[0] = '{4'd2,  1'b1, 8'h00, 1'b1, 8'h04, 1'b0, 10'd0, 4'd2,  16'd0, 1'b0, 1'b1};
    tv[1] = '{4'd0,  1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 10'd5, 4'd2,  16'd0, 1'b0, 1'b1};
    tv[2] = '{4'd0,  1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 10'd0, 4'd2,  16'd1, 1'b0, 1'b1};
    tv[3] = '{4'd12, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd2,  16'd1, 1'b0, 1'b1};
    tv[4] = '{4'd0,  1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b1, 1'b0};
    tv[5] = '{4'd0,  1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b0, 1'b0};
    tv[6] = '{4'd12, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b1, 1'b0};
    tv[7] = '{4'd15, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b0, 1'b0};
    tv[8] = '{4'd9,  1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b1, 1'b0};
    tv[9] = '{4'd0,  1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 10'd0, 4'd15, 16'd1, 1'b0, 1'b0};

    for (int i = 0; i < NS; i++) begin
      sx[i] = 10'($urandom);
      sy[i] = 9'($urandom);
      sc[i] = 8'($urandom);
    end
    sx[2] = 10'd5; sy[2] = 9'd7; sc[2] = 8'hAA;
    SEL = 4'd0; SEL_LOAD = 1'b0; IN_VALID = '0; OUT_READY = 1'b0;
    RST = 1'b1;
    model_reset();
    #12;
    check_all();
    chk("reset_out_x", 32'(OUT_X), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Directed vector table: first beat, idle/illegal selects, drain to idle
    for (int i = 0; i < 10; i++) begin
      step(tv[i].sel, tv[i].ld, tv[i].vld, tv[i].ordy, acc);
      chk($sformatf("tv%0d_in_ready", i), 32'(IN_READY), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d_out_valid", i), 32'(OUT_VALID), 32'(tv[i].e_ov));
      if (tv[i].e_ov) chk($sformatf("tv%0d_out_x", i), 32'(OUT_X), 32'(tv[i].e_x));
      chk($sformatf("tv%0d_act_sel", i), 32'(ACT_SEL), 32'(tv[i].e_act));
      chk($sformatf("tv%0d_beat_cnt", i), 32'(BEAT_CNT), 32'(tv[i].e_bc));
      chk($sformatf("tv%0d_sel_err", i), 32'(SEL_ERR), 32'(tv[i].e_err));
      chk($sformatf("tv%0d_busy", i), 32'(BUSY), 32'(tv[i].e_busy));
    end

    // Stream 10 beats from source 2 with OUT_READY toggling 1010...
    do_reset();
    step(4'd2, 1'b1, 8'h00, 1'b1, acc);
    sent = 0;
    sx[2] = 10'd100; sy[2] = 9'd200; sc[2] = 8'h10;
    for (int k = 0; k < 40 && sent < 10; k++) begin
      step(4'd0, 1'b0, 8'h04, (k % 2) == 0, acc);
      if (acc) begin
        sent++;
        sx[2] = 10'(100 + sent); sy[2] = 9'(200 + sent); sc[2] = 8'(8'h10 + sent);
      end
    end
    chk("stream_sent", 32'(sent), 32'd10);
    for (int k = 0; k < 4; k++) step(4'd0, 1'b0, 8'h00, 1'b1, acc);
    chk("stream_beat_cnt", 32'(BEAT_CNT), 32'd10);

    // Mid-stream switch to 4 with two beats buffered and a 3-cycle stall
    step(4'd0, 1'b0, 8'h04, 1'b0, acc);
    step(4'd0, 1'b0, 8'h04, 1'b0, acc);
    step(4'd4, 1'b1, 8'h14, 1'b0, acc);
    step(4'd0, 1'b0, 8'h14, 1'b0, acc);
    step(4'd0, 1'b0, 8'h14, 1'b0, acc);
    chk("drain_in_ready", 32'(IN_READY), 32'd0);
    step(4'd0, 1'b0, 8'h14, 1'b1, acc);
    step(4'd0, 1'b0, 8'h14, 1'b1, acc);
    step(4'd0, 1'b0, 8'h00, 1'b1, acc);
    chk("switch_act_sel", 32'(ACT_SEL), 32'd4);
    chk("switch_beat_cnt", 32'(BEAT_CNT), 32'd0);
    step(4'd0, 1'b0, 8'h10, 1'b0, acc);
    chk("src4_accepted", 32'(acc), 32'd1);

    // Two loads in DRAIN (3 then 1): last wins, source 3 never granted
    saw3 = 0;
    step(4'd3, 1'b1, 8'h08, 1'b0, acc); saw3 |= IN_READY[3];
    step(4'd1, 1'b1, 8'h08, 1'b0, acc); saw3 |= IN_READY[3];
    step(4'd0, 1'b0, 8'h08, 1'b1, acc); saw3 |= IN_READY[3];
    step(4'd0, 1'b0, 8'h08, 1'b0, acc); saw3 |= IN_READY[3];
    step(4'd0, 1'b0, 8'h08, 1'b0, acc); saw3 |= IN_READY[3];
    chk("last_load_wins", 32'(ACT_SEL), 32'd1);
    chk("src3_never_ready", 32'(saw3), 32'd0);

    // Asynchronous reset while RUN with two beats buffered
    do_reset();
    step(4'd2, 1'b1, 8'h00, 1'b1, acc);
    step(4'd0, 1'b0, 8'h04, 1'b1, acc);
    step(4'd0, 1'b0, 8'h04, 1'b1, acc);
    step(4'd0, 1'b0, 8'h04, 1'b0, acc);
    chk("pre_rst_full", 32'(OUT_VALID && IN_READY == 8'h00 && BEAT_CNT == 16'd1), 32'd1);
    #3;
    RST = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("async_rst_act_sel", 32'(ACT_SEL), 32'd15);
    chk("async_rst_beat_cnt", 32'(BEAT_CNT), 32'd0);
    chk("async_rst_in_ready", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    check_all();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      int r;
      logic [3:0] s;
      for (int i = 0; i < NS; i++) begin
        sx[i] = 10'($urandom);
        sy[i] = 9'($urandom);
        sc[i] = 8'($urandom);
      end
      r = $urandom_range(0, 9);
      if (r < 7)       s = 4'($urandom_range(0, 7));
      else if (r == 7) s = 4'd15;
      else             s = 4'($urandom_range(8, 14));
      step(s, $urandom_range(0, 9) == 0, 8'($urandom), 1'($urandom), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_px_mux.md
Name: draw_px_mux

Overview:
- Parametrised, handshaked pixel-stream multiplexer between the N drawing engines and the framebuffer writer.
- Drawing engines include circle fill/draw, rect fill/draw, line, and frame update.
- Carries X, Y and colour together with valid/ready flow control through a 2-entry output buffer.
- Source switches are drained-safe: a new SEL takes effect only after every in-flight beat of the old source has been delivered.

Parameters:
- NUM_SRC, 8, number of engine channels (1..15).
- X_W, 10, X coordinate width.
- Y_W, 9, Y coordinate width.
- C_W, 8, colour width.
- SEL_W, 4, select width.
- IDLE_SEL, 15, select code meaning idle/no source.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- SEL  in  SEL_W  requested source.
- SEL_LOAD  in  1  one-cycle strobe to apply SEL.
- IN_X  in  NUM_SRC*X_W  packed X per source; source i occupies [i*X_W +: X_W].
- IN_Y  in  NUM_SRC*Y_W  packed Y per source.
- IN_C  in  NUM_SRC*C_W  packed colour per source.
- IN_VALID  in  NUM_SRC  per-source valid.
- IN_READY  out  NUM_SRC  per-source ready.
- OUT_X  out  X_W  registered pixel X.
- OUT_Y  out  Y_W  registered pixel Y.
- OUT_C  out  C_W  registered pixel colour.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  framebuffer writer ready.
- ACT_SEL  out  SEL_W  currently active source.
- BUSY  out  1  state != IDLE or buffer non-empty.
- SEL_ERR  out  1  one-cycle pulse on an illegal select.
- BEAT_CNT  out  16  beats delivered since last entry to RUN; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE, ACT_SEL=IDLE_SEL, buffer count=0.
  - OUT_X/OUT_Y/OUT_C=0, OUT_VALID=0, SEL_ERR=0, BEAT_CNT=0, pending select=IDLE_SEL.
  - Buffered beats are discarded. Reset mid-stream gives no partial output.
- Buffer:
  - Two entries, main and skid. OUT_* driven from main; OUT_VALID = count!=0.
  - pop = OUT_VALID & OUT_READY.
  - push = IN_VALID[ACT_SEL] & IN_READY[ACT_SEL].
  - FIFO order is preserved. On pop with count==2, skid moves to main.
  - On push+pop with count==1, main takes the new beat and count stays 1.
  - OUT_* hold stable while OUT_VALID=1 and OUT_READY=0.
- IN_READY:
  - IN_READY[i] = (state==RUN) & (i==ACT_SEL) & (count<2); all other bits 0.
  - IN_READY is a function of registered state only; there is no combinational path from OUT_READY.
- Latency: a beat accepted at edge t with count==0 appears on OUT_* with OUT_VALID=1 after edge t, i.e. one cycle.
- Throughput: 1 beat/cycle with OUT_READY held high.
- Select legality: a SEL value is legal if SEL < NUM_SRC. SEL==IDLE_SEL means go idle. Any other value is illegal.
- State IDLE:
  - On SEL_LOAD with legal SEL: ACT_SEL<=SEL, BEAT_CNT<=0, go to RUN.
  - On SEL_LOAD with IDLE_SEL: stay in IDLE.
  - On SEL_LOAD with an illegal value: SEL_ERR=1 for 1 cycle, stay in IDLE.
- State RUN:
  - Accept beats from ACT_SEL.
  - On SEL_LOAD: pending<=SEL, go to DRAIN. IN_READY is 0 from the next cycle.
  - A beat pushed in the same cycle as SEL_LOAD belongs to the old source and is delivered.
- State DRAIN:
  - No pushes.
  - A further SEL_LOAD overwrites pending (last one wins).
  - When count==0, pending is applied with the IDLE rules: legal → RUN with new ACT_SEL and BEAT_CNT cleared; IDLE_SEL → IDLE with ACT_SEL=IDLE_SEL; illegal → SEL_ERR pulse, IDLE, ACT_SEL=IDLE_SEL.
  - SEL_LOAD and count reaching 0 in the same cycle: the new SEL replaces pending before it is applied.
- BEAT_CNT increments on each pop, stops at 16'hFFFF, and clears only on entry to RUN or on reset.
- Reselecting the same source still goes through DRAIN.

Test Plan:
- Reset, then SEL=2 with SEL_LOAD; drive source 2 with X=5, Y=7, C=8'hAA, valid; OUT_READY=1 → OUT shows (5,7,AA) one cycle after acceptance; IN_READY=8'b00000100; BEAT_CNT=1.
- Source 2 streams 10 beats, OUT_READY toggling 1010… → all 10 beats out in order with no duplicates; IN_READY drops when count==2; OUT_* stable while stalled.
- Mid-stream SEL=4 load with 2 beats buffered and OUT_READY=0 for 3 cycles → IN_READY=0 throughout; both old beats delivered; then ACT_SEL=4, BEAT_CNT=0, source 4 accepted.
- SEL=12 with NUM_SRC=8 (from IDLE and via DRAIN) → SEL_ERR single-cycle pulse; ACT_SEL=15; BUSY falls after drain.
- Assert RST while count==2 and RUN → OUT_VALID=0, ACT_SEL=15, BEAT_CNT=0 immediately, with no clock edge needed.
- Two SEL_LOADs in DRAIN (3 then 1) → ACT_SEL=1 after drain; source 3 never granted.
